// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared states, pixel layout and defaults for matrix_scan
package matrix_pkg;

  localparam int DEF_BUS_WIDTH = 32;
  localparam int DEF_ROW_COUNT = 8;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_BLANK     = 4;
  localparam int DEF_DWELL     = 256;

  localparam int PIX_R = 2;
  localparam int PIX_G = 1;
  localparam int PIX_B = 0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_BLANK   = 3'd4;
  localparam logic [2:0] S_LATCH   = 3'd5;
  localparam logic [2:0] S_DISPLAY = 3'd6;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_shifter.sv
// rtl/matrix_shifter.sv - RGB plane serialiser with divided sclk and start/done handshake
module matrix_shifter
  import matrix_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [BUS_WIDTH-1:0] i_data,
  output logic                 o_sclk,
  output logic                 o_sdata,
  output logic                 o_done
);

  localparam int COLS  = BUS_WIDTH / 4;
  localparam int NBITS = 3 * COLS;
  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam int BIT_W = cnt_width(NBITS);

  logic [NBITS-1:0] w_order;
  logic [COLS-1:0]  w_unused_b3;
  logic [NBITS-1:0] r_shreg;
  logic [DIV_W-1:0] r_div;
  logic [BIT_W-1:0] r_bit;
  logic             r_busy;
  logic             r_phase;
  logic             w_div_end;

  // MSB of w_order leaves first: R plane, then G, then B, high column first.
  for (genvar k = 0; k < COLS; k++) begin : g_col
    assign w_order[2*COLS+k] = i_data[4*k+PIX_R];
    assign w_order[COLS+k]   = i_data[4*k+PIX_G];
    assign w_order[k]        = i_data[4*k+PIX_B];
    assign w_unused_b3[k]    = i_data[4*k+3];
  end

  assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
  assign o_done    = r_busy && r_phase && w_div_end && (r_bit == BIT_W'(NBITS - 1));
  assign o_sclk    = r_phase;
  assign o_sdata   = r_busy && r_shreg[NBITS-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_phase <= 1'b0;
    end else if (i_start) begin
      r_shreg <= w_order;
      r_div   <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b1;
      r_phase <= 1'b0;
    end else if (r_busy) begin
      if (w_div_end) begin
        r_div   <= '0;
        r_phase <= !r_phase;
        // Data only advances at the end of the high phase, so it is stable while sclk is high.
        if (r_phase) begin
          r_shreg <= {r_shreg[NBITS-2:0], 1'b0};
          if (o_done) begin
            r_busy <= 1'b0;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_scan.sv
// rtl/matrix_scan.sv - LED matrix row scanner: fetch, shift, blank, latch, display
module matrix_scan
  import matrix_pkg::*;
#(
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int ROW_COUNT  = DEF_ROW_COUNT,
  parameter int ADDR_WIDTH = $clog2(ROW_COUNT),
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int BLANK      = DEF_BLANK,
  parameter int DWELL      = DEF_DWELL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_enable,
  output logic                  o_fb_rd,
  output logic [ADDR_WIDTH-1:0] o_fb_addr,
  input  logic [BUS_WIDTH-1:0]  i_fb_data,
  output logic                  o_sclk,
  output logic                  o_sdata,
  output logic                  o_latch,
  output logic                  o_oe_n,
  output logic [ROW_COUNT-1:0]  o_row,
  output logic                  o_frame_start
);

  localparam int CNT_W = cnt_width((BLANK > DWELL) ? BLANK : DWELL);

  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_row_idx;
  logic [ROW_COUNT-1:0]  r_row;
  logic                  r_lit;
  logic                  w_start;
  logic                  w_shift_done;
  logic                  w_blank_end;
  logic                  w_dwell_end;
  logic                  w_lit_state;

  assign w_start = (r_state == S_WAIT);

  matrix_shifter #(
    .BUS_WIDTH (BUS_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_start),
    .i_data  (i_fb_data),
    .o_sclk  (o_sclk),
    .o_sdata (o_sdata),
    .o_done  (w_shift_done)
  );

  assign w_blank_end = (r_cnt == CNT_W'(BLANK - 1));
  assign w_dwell_end = (r_cnt == CNT_W'(DWELL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_row_idx <= '0;
      r_row     <= '0;
      r_lit     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (i_enable) r_state <= S_FETCH;
        S_FETCH: r_state <= S_WAIT;
        S_WAIT:  r_state <= S_SHIFT;
        S_SHIFT: begin
          if (w_shift_done) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
          end
        end
        S_BLANK: begin
          // Row select moves on the edge into LATCH so it is already valid during the latch pulse.
          if (w_blank_end) begin
            r_state   <= S_LATCH;
            r_cnt     <= '0;
            r_row     <= ROW_COUNT'(1) << r_row_idx;
            r_row_idx <= (r_row_idx == ADDR_WIDTH'(ROW_COUNT - 1)) ? '0 : r_row_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          r_state <= S_DISPLAY;
          r_lit   <= 1'b1;
        end
        S_DISPLAY: begin
          if (w_dwell_end) begin
            r_cnt <= '0;
            if (i_enable) begin
              r_state <= S_FETCH;
            end else begin
              r_state   <= S_IDLE;
              r_row     <= '0;
              r_lit     <= 1'b0;
              r_row_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The previously latched row stays lit while the next one is fetched and shifted.
  assign w_lit_state = (r_state == S_FETCH) || (r_state == S_WAIT) ||
                       (r_state == S_SHIFT) || (r_state == S_DISPLAY);

  assign o_fb_rd       = (r_state == S_FETCH);
  assign o_fb_addr     = r_row_idx;
  assign o_latch       = (r_state == S_LATCH);
  assign o_row         = r_row;
  assign o_oe_n        = !(r_lit && w_lit_state);
  assign o_frame_start = o_latch && r_row[0];

endmodule

// File: doc/matrix_scan.md
MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32: framebuffer row width, one 4-bit pixel per column.
REQ-002 SHALL have parameter ROW_COUNT, default 8: rows scanned; column count = BUS_WIDTH/4.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(ROW_COUNT): framebuffer address width.
REQ-004 SHALL have parameter CLK_DIV, default 2: clk cycles per sclk half-period, minimum 1.
REQ-005 SHALL have parameter BLANK, default 4: clk cycles of output blanking before a latch, minimum 1.
REQ-006 SHALL have parameter DWELL, default 256: clk cycles in DISPLAY, minimum 1.
REQ-007 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-008 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port i_enable, input, 1: scan enable.
REQ-010 SHALL have port o_fb_rd, output, 1: framebuffer read strobe.
REQ-011 SHALL have port o_fb_addr, output, ADDR_WIDTH: framebuffer row address.
REQ-012 SHALL have port i_fb_data, input, BUS_WIDTH: row data, valid the cycle after o_fb_rd.
REQ-013 SHALL have port o_sclk, output, 1: column shift-register clock.
REQ-014 SHALL have port o_sdata, output, 1: column serial data.
REQ-015 SHALL have port o_latch, output, 1: shift-register storage latch pulse.
REQ-016 SHALL have port o_oe_n, output, 1: column output enable, active low.
REQ-017 SHALL have port o_row, output, ROW_COUNT: one-hot active-high row select.
REQ-018 SHALL have port o_frame_start, output, 1: one-cycle pulse when row 0 is latched.

Function
REQ-019 SHALL decode pixel nibble k (bits 4k+3:4k) as column k: bit2 R, bit1 G, bit0 B, bit3 ignored.
REQ-020 SHALL shift 3*COLS bits MSB-first in order R[COLS-1..0], G[COLS-1..0], B[COLS-1..0].
REQ-021 SHALL implement states IDLE, FETCH, WAIT, SHIFT, BLANK, LATCH, DISPLAY.
REQ-022 SHALL go IDLE->FETCH when i_enable=1; DISPLAY->FETCH after DWELL cycles if i_enable=1, else DISPLAY->IDLE.
REQ-023 SHALL assert o_fb_rd for exactly the one FETCH cycle, o_fb_addr = next row index.
REQ-024 SHALL capture i_fb_data into the shift register in WAIT (one cycle), then enter SHIFT.
REQ-025 SHALL per bit in SHIFT: drive o_sdata with o_sclk low for CLK_DIV cycles, then o_sclk high for CLK_DIV cycles; o_sdata stable while o_sclk high.
REQ-026 SHALL enter BLANK after the last sclk high phase, hold it BLANK cycles, then LATCH for one cycle (o_latch=1, o_row updated to new row the same cycle), then DISPLAY.
REQ-027 SHALL drive o_oe_n=1 in IDLE, BLANK, LATCH and before the first latch after leaving IDLE; o_oe_n=0 in all other states (previous row stays lit while the next shifts).
REQ-028 SHALL increment the row index modulo ROW_COUNT on each LATCH, wrapping ROW_COUNT-1->0; the first row fetched after IDLE is 0.
REQ-029 SHALL pulse o_frame_start for the LATCH cycle of row 0 only.
REQ-030 SHALL give row period 2 + 2*CLK_DIV*3*COLS + BLANK + 1 + DWELL cycles (defaults: 359).
REQ-031 SHALL ignore i_enable deassertion until DISPLAY completes; on entry to IDLE drive o_row=0, o_oe_n=1.

Reset
REQ-032 SHALL on reset_n=0 immediately force IDLE, row index 0, o_row=0, o_oe_n=1, o_sclk=0, o_sdata=0, o_latch=0, o_fb_rd=0, o_fb_addr=0, o_frame_start=0, all counters 0.
REQ-033 SHALL, when reset asserts mid-SHIFT, restart from row 0 after release with no latch of partial data.

Structure
REQ-034 SHALL place the state enum, pixel bit positions (R=2,G=1,B=0) and parameter defaults in shared package matrix_pkg.
REQ-035 SHALL implement serialisation (shift register, CLK_DIV divider, bit counter) in sub-module matrix_shifter with start/done handshake.

Verification
REQ-036 SHALL cover: reset release, i_enable=1 -> o_fb_rd at addr 0 two cycles later, o_oe_n=1 until first LATCH.
REQ-037 SHALL cover: row 0 = 0x00000004 (col0 red) -> 24 sclk rises, sdata high only on bit 8 (R0, 8th shifted), o_row=0x01 at latch.
REQ-038 SHALL cover: free-run 8 rows -> addresses 0..7 then 0, o_frame_start every 8*359 cycles, o_row one-hot sequence 0x01..0x80.
REQ-039 SHALL cover: nibble 0xF in every column -> bit3 ignored, all 24 bits high.
REQ-040 SHALL cover: i_enable dropped mid-SHIFT -> row completes DISPLAY, then IDLE with o_row=0, o_oe_n=1.
REQ-041 SHALL cover: reset_n pulsed mid-SHIFT -> outputs at reset values same cycle, no o_latch, restart at row 0.
